// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder datapath: the control state
// encoding (used by the operand serializer and the adder control FSM),
// the default word width and a helper that sizes bit counters.
package serial_adder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SA_WIDTH = 8;

  // Smallest counter width able to index bits 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, right-shifting register with zero fill. Bit 0 is the
// serial output. Priority: clr > load > shift.
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         lsb
);

  logic [W-1:0] sh;

  // Load a fresh word, or shift one place towards the LSB.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
    end else if (clr) begin
      sh <= '0;
    end else if (load) begin
      sh <= d;
    end else if (shift) begin
      sh <= {1'b0, sh[W-1:1]};
    end
  end

  assign lsb = sh[0];

endmodule

// File: rtl/operand_serializer.sv
// Parallel-in, serial-out front end of the serial adder. Captures two
// N-bit operands on a valid/ready handshake and emits them LSB-first, one
// bit pair per clock, framed by first_bit / last_bit.
// Optional stall input: define SER_HOLD_EN to add the hold port.
module operand_serializer
  import serial_adder_pkg::*;
#(
  parameter int N     = SA_WIDTH,
  parameter int CNT_W = cnt_width(N)
) (
  input  logic         i_clk,
  input  logic         reset,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         clr,
`ifdef SER_HOLD_EN
  input  logic         hold,
`endif
  output logic         a_bit,
  output logic         b_bit,
  output logic         bit_valid,
  output logic         first_bit,
  output logic         last_bit,
  output logic         busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             in_shift;
  logic             take;
  logic             advance;
  logic             at_last;
  logic             a_lsb;
  logic             b_lsb;

  assign in_shift = (state == SHIFT);
  // clr beats a same-edge transfer: the operands are simply not loaded.
  assign take     = !in_shift && in_valid && !clr;
  assign at_last  = (cnt == CNT_W'(N - 1));

`ifdef SER_HOLD_EN
  // A held word neither shifts nor counts; the sum side sees no valid bit.
  assign advance  = in_shift && !hold;
`else
  assign advance  = in_shift;
`endif

  piso_shift_reg #(.W(N)) u_sh_a (
    .clk   (i_clk),
    .rst_n (reset),
    .clr   (clr),
    .load  (take),
    .shift (advance),
    .d     (a_in),
    .lsb   (a_lsb)
  );

  piso_shift_reg #(.W(N)) u_sh_b (
    .clk   (i_clk),
    .rst_n (reset),
    .clr   (clr),
    .load  (take),
    .shift (advance),
    .d     (b_in),
    .lsb   (b_lsb)
  );

  // Control FSM and bit counter: IDLE waits for a transfer, SHIFT walks cnt
  // from 0 to N-1 and always drops back to IDLE after the last bit.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (advance) begin
            if (at_last) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output
  // combinationally (except the optional hold stall on bit_valid).
  assign in_ready  = !in_shift;
  assign busy      = in_shift;
  assign bit_valid = advance;
  assign a_bit     = in_shift && a_lsb;
  assign b_bit     = in_shift && b_lsb;
  assign first_bit = in_shift && (cnt == '0);
  assign last_bit  = in_shift && at_last;

endmodule

// File: tb/tb_operand_serializer.sv
// Self-checking bench for operand_serializer (default build, N=8).
// A word-level reference model (active flag, bit index, captured operands)
// predicts every output after each rising edge.
module tb_operand_serializer;

  localparam int N = 8;

  logic         i_clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] b_in = '0;
  logic         in_valid = 1'b0;
  logic         clr = 1'b0;
  logic         in_ready, a_bit, b_bit, bit_valid, first_bit, last_bit, busy;
`ifdef SER_HOLD_EN
  logic         hold = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  bit           m_active = 1'b0;
  int           m_idx = 0;
  logic [N-1:0] m_a = '0;
  logic [N-1:0] m_b = '0;

  operand_serializer #(.N(N), .CNT_W(3)) dut (
    .i_clk     (i_clk),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clr       (clr),
`ifdef SER_HOLD_EN
    .hold      (hold),
`endif
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .bit_valid (bit_valid),
    .first_bit (first_bit),
    .last_bit  (last_bit),
    .busy      (busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word-level behaviour at a rising edge, from the inputs present at it.
  task automatic model_edge();
    if (clr) begin
      m_active = 1'b0;
      m_idx    = 0;
    end else if (m_active) begin
      if (m_idx == N - 1) begin
        m_active = 1'b0;
        m_idx    = 0;
      end else begin
        m_idx++;
      end
    end else if (in_valid) begin
      m_active = 1'b1;
      m_idx    = 0;
      m_a      = a_in;
      m_b      = b_in;
    end
  endtask

  task automatic check_model();
    check_bit("in_ready",  in_ready,  !m_active);
    check_bit("busy",      busy,      m_active);
    check_bit("bit_valid", bit_valid, m_active);
    check_bit("a_bit",     a_bit,     m_active ? m_a[m_idx] : 1'b0);
    check_bit("b_bit",     b_bit,     m_active ? m_b[m_idx] : 1'b0);
    check_bit("first_bit", first_bit, m_active && (m_idx == 0));
    check_bit("last_bit",  last_bit,  m_active && (m_idx == N - 1));
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    check_bit({tag, "_in_ready"},  in_ready,  1'b1);
    check_bit({tag, "_busy"},      busy,      1'b0);
    check_bit({tag, "_bit_valid"}, bit_valid, 1'b0);
    check_bit({tag, "_a_bit"},     a_bit,     1'b0);
    check_bit({tag, "_b_bit"},     b_bit,     1'b0);
    check_bit({tag, "_first_bit"}, first_bit, 1'b0);
    check_bit({tag, "_last_bit"},  last_bit,  1'b0);
  endtask

  // Transfer one word from IDLE and collect its serial stream; operand
  // inputs are scrambled after the transfer edge to show they are ignored.
  task automatic run_word(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] got_a, output logic [N-1:0] got_b,
                          output int firsts, output int last_pos);
    got_a    = '0;
    got_b    = '0;
    firsts   = 0;
    last_pos = -1;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      step();
      in_valid = 1'b0;
      a_in     = N'($urandom);
      b_in     = N'($urandom);
      got_a[i] = a_bit;
      got_b[i] = b_bit;
      if (first_bit) firsts++;
      if (last_bit) last_pos = i;
    end
  endtask

  // Bounded wait for the block to return to IDLE.
  task automatic drain(input string tag);
    in_valid = 1'b0;
    clr      = 1'b0;
    for (int i = 0; i < N + 2 && busy; i++) step();
    check_bit(tag, in_ready, 1'b1);
  endtask

  initial begin
    logic [N-1:0] ga, gb;
    int           firsts, last_pos, first_cnt;

    // Reset applied from time 0: outputs at reset values immediately.
    #1;
    check_reset_values("reset");
    #12 reset = 1'b1;
    step();
    step();

    // Scenario 1: A5 / 3C.
    run_word(8'hA5, 8'h3C, ga, gb, firsts, last_pos);
    check_word("s1_seq_a", ga, 8'hA5);
    check_word("s1_seq_b", gb, 8'h3C);
    check_word("s1_first_count", N'(firsts), N'(1));
    check_word("s1_last_pos", N'(last_pos), N'(N - 1));
    step();
    check_bit("s1_ready_after", in_ready, 1'b1);

    // Scenario 2: in_valid held high, new operands every cycle.
    first_cnt = 0;
    in_valid  = 1'b1;
    for (int i = 0; i < 45; i++) begin
      a_in = N'($urandom);
      b_in = N'($urandom);
      step();
      if (first_bit) first_cnt++;
    end
    check_word("s2_captures_45cyc", N'(first_cnt), N'(5));
    drain("s2_drain");

    // Scenario 3: clr on the 4th bit, then FF / 01.
    a_in     = N'($urandom);
    b_in     = N'($urandom);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_bit("s3_clr_bit_valid", bit_valid, 1'b0);
    check_bit("s3_clr_in_ready", in_ready, 1'b1);
    check_bit("s3_clr_no_last", last_bit, 1'b0);
    run_word(8'hFF, 8'h01, ga, gb, firsts, last_pos);
    check_word("s3_seq_a", ga, 8'hFF);
    check_word("s3_seq_b", gb, 8'h01);
    drain("s3_drain");

    // Scenario 4: asynchronous reset between edges, mid-word.
    a_in     = N'($urandom);
    b_in     = N'($urandom);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    m_active = 1'b0;
    m_idx    = 0;
    #1 reset = 1'b1;
    step();
    run_word(8'hA5, 8'h3C, ga, gb, firsts, last_pos);
    check_word("s4_seq_a", ga, 8'hA5);
    check_word("s4_seq_b", gb, 8'h3C);
    check_word("s4_last_pos", N'(last_pos), N'(N - 1));
    drain("s4_drain");

    // Scenario 5: clr and a transfer on the same edge.
    a_in     = 8'h5A;
    b_in     = 8'hC3;
    in_valid = 1'b1;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    check_bit("s5_bit_valid", bit_valid, 1'b0);
    check_bit("s5_in_ready", in_ready, 1'b1);
    step();
    check_bit("s5_still_idle", bit_valid, 1'b0);

    // Randomized traffic with occasional clr.
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 15) == 0);
      a_in     = N'($urandom);
      b_in     = N'($urandom);
      step();
    end
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_serializer.md
Name: operand_serializer

Overview:
- Parallel-in, serial-out front end of the serial adder datapath.
- Accepts two N-bit operands through a valid/ready handshake. Emits them LSB-first, one bit pair per clock, into the Mealy-machine full adder.
- Marks the first and last bit so the downstream sum shift register and carry flop can frame the word.
- Transmit-side counterpart of the sum-collecting shift register.

Parameters:
- N, 8, operand width in bits (N >= 2).
- CNT_W, 3, bit-counter width; must satisfy 2**CNT_W >= N.

Ports:
- i_clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_in  input  N  operand A, parallel.
- b_in  input  N  operand B, parallel.
- in_valid  input  1  operands on a_in/b_in are valid.
- in_ready  output  1  block can accept operands.
- clr  input  1  synchronous abort, active-high.
- a_bit  output  1  current serial bit of A.
- b_bit  output  1  current serial bit of B.
- bit_valid  output  1  a_bit/b_bit are valid this cycle.
- first_bit  output  1  current bit is bit 0 (carry flop must use carry-in 0).
- last_bit  output  1  current bit is bit N-1.
- busy  output  1  word in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift registers, counter = 0.
  - in_ready=1; all other outputs 0.
- Clock/reset: one clock, i_clk; reset is asynchronous, active-low.
- States:
  - IDLE: in_ready=1, bit_valid=0, busy=0.
    - On in_valid & in_ready: capture a_in/b_in into a_sh/b_sh, cnt=0, go to SHIFT.
  - SHIFT: in_ready=0, busy=1, bit_valid=1.
    - a_bit=a_sh[0], b_bit=b_sh[0].
    - first_bit=(cnt==0); last_bit=(cnt==N-1).
    - Each edge: a_sh/b_sh shift right with 0 fill, cnt+1.
    - When last_bit=1, next state is IDLE.
- Latency:
  - Handshake edge k → bit 0 visible in cycle k+1.
  - Bit N-1 visible in cycle k+N.
  - in_ready returns in cycle k+N+1.
  - Throughput: one word per N+1 cycles (one bubble, IDLE always re-entered).
- Handshake rules:
  - Transfer occurs only when in_valid and in_ready are both 1 on a rising edge.
  - in_valid held high during SHIFT is ignored; no capture, no queueing.
  - a_in/b_in are sampled only at the transfer edge; later changes have no effect.
- Outputs are registered state or decode of registered state; no combinational path from inputs to outputs.
- Counter: never exceeds N-1; no wrap occurs inside a word.
- clr:
  - Any state: next state IDLE, registers zeroed, no bit_valid on the following cycle.
  - clr and a transfer on the same edge: clr wins, operands discarded, in_ready stays 1.
- Reset mid-word: immediate return to reset values; partial word lost; no last_bit emitted.
- N=2 boundary: first_bit and last_bit are asserted in consecutive cycles, never together.

Optional Feature:
- Macro: SER_HOLD_EN.
- Defined:
  - Adds input port hold (1 bit).
  - While in SHIFT with hold=1: shift registers and cnt frozen; bit_valid=0; a_bit/b_bit/first_bit/last_bit keep their values.
  - Lets the sum side stall.
  - hold is ignored in IDLE; clr and reset override hold.
- Not defined:
  - No hold port.
  - SHIFT always advances every cycle.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum (IDLE, SHIFT), also reused by the adder control FSM.
  - default width constant SA_WIDTH=8.
  - function computing CNT_W from N.
- One natural sub-module: piso_shift_reg (parallel load, right shift, 0 fill).
  - Instantiated twice, for A and B.
  - Control FSM and counter stay in operand_serializer.

Test Plan:
- Reset release, then in_valid=1 with a_in=8'hA5, b_in=8'h3C:
  - in_ready=0 next cycle.
  - a_bit sequence 1,0,1,0,0,1,0,1; b_bit sequence 0,0,1,1,1,1,0,0.
  - first_bit on cycle 1 only; last_bit on cycle 8 only; in_ready=1 on cycle 9.
- in_valid held high continuously with new values each cycle:
  - Captures occur exactly every 9 cycles.
  - Data mid-word has no effect on the bit stream.
- clr asserted on the 4th bit of a word:
  - bit_valid=0 and in_ready=1 on the next cycle; no last_bit.
  - A new word 8'hFF/8'h01 then serializes correctly.
- reset pulsed low asynchronously mid-word (between edges):
  - Outputs go to reset values immediately.
  - Recovery transfer behaves as in the first scenario.
- clr and a transfer on the same edge: no capture, bit_valid stays 0, in_ready stays 1.
- With SER_HOLD_EN, hold=1 for 3 cycles after bit 2:
  - bit_valid=0 for those cycles; bit 3 value unchanged.
  - Word completes in 8+3 SHIFT cycles with the correct sequence.
